// File: rtl/note_gen_pkg.sv
// Shared types and helpers for the note lane generator.
//   lane_state_t : per-lane FSM encoding (IDLE, ARMED, RUN)
//   clamp_next   : next coordinate = min(cur + step, stop), evaluated wide
//                  enough that the addition can never overflow.
package note_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } lane_state_t;

  // Widest coordinate supported; one extra bit holds the carry of cur+step.
  localparam int MAX_W = 32;

  function automatic logic [MAX_W:0] clamp_next(input logic [MAX_W:0] cur,
                                                input logic [MAX_W:0] step,
                                                input logic [MAX_W:0] stop);
    logic [MAX_W:0] sum;
    sum = cur + step;
    return (sum > stop) ? stop : sum;
  endfunction

endpackage

// File: rtl/note_lane.sv
// One note lane: FSM (IDLE/ARMED/RUN) plus coordinate register.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   tick        : step strobe
//   spawn       : launch/retrigger this lane (to ARMED at START)
//   clear       : abort this lane (to IDLE at START, no done)
//   pos         : registered coordinate
//   active      : lane is ARMED or RUN (registered state)
//   done        : registered one-cycle pulse after the lane passes STOP
//   done_set    : combinational, high when done will be set on this edge
module note_lane
  import note_gen_pkg::*;
#(
  parameter int W         = 8,
  parameter int START     = 160,
  parameter int STOP      = 176,
  parameter int STEP      = 4,
  parameter int MODE_WRAP = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         spawn,
  input  logic         clear,
  output logic [W-1:0] pos,
  output logic         active,
  output logic         done,
  output logic         done_set
);

  localparam logic [W-1:0] START_V = W'(START);
  localparam logic [W-1:0] STOP_V  = W'(STOP);

  lane_state_t  state_reg, state_next;
  logic [W-1:0] pos_reg, pos_next;
  logic         done_reg, done_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      pos_reg   <= START_V;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pos_reg   <= pos_next;
      done_reg  <= done_next;
    end
  end

  // Priority: clear > spawn > tick > hold.
  always_comb begin
    state_next = state_reg;
    pos_next   = pos_reg;
    done_next  = 1'b0;
    if (clear) begin
      state_next = IDLE;
      pos_next   = START_V;
    end else if (spawn) begin
      state_next = ARMED;
      pos_next   = START_V;
    end else if (tick) begin
      case (state_reg)
        ARMED: state_next = RUN;   // launch latency: no movement on this tick
        RUN: begin
          if (pos_reg == STOP_V) begin
            done_next  = 1'b1;
            pos_next   = START_V;
            state_next = (MODE_WRAP != 0) ? RUN : IDLE;
          end else begin
            pos_next = W'(clamp_next((MAX_W+1)'(pos_reg),
                                     (MAX_W+1)'(STEP),
                                     (MAX_W+1)'(STOP)));
          end
        end
        default: state_next = state_reg;
      endcase
    end
  end

  assign pos      = pos_reg;
  assign active   = (state_reg != IDLE);
  assign done     = done_reg;
  assign done_set = done_next;

endmodule

// File: rtl/note_lane_generator.sv
// Multi-lane note position generator for the playfield.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   tick        : step strobe shared by all lanes
//   spawn[L]    : per-lane launch/retrigger
//   clear[L]    : per-lane abort
//   pos[L*W]    : lane i coordinate at [i*W +: W]
//   active[L]   : lane ARMED or RUN
//   done[L]     : one-cycle completion pulse per lane
//   done_count  : saturating total of completions
//   busy        : any lane active
module note_lane_generator
  import note_gen_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int W         = 8,
  parameter int START     = 160,
  parameter int STOP      = 176,
  parameter int STEP      = 4,
  parameter int MODE_WRAP = 1,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [LANES-1:0]   spawn,
  input  logic [LANES-1:0]   clear,
  output logic [LANES*W-1:0] pos,
  output logic [LANES-1:0]   active,
  output logic [LANES-1:0]   done,
  output logic [CNT_W-1:0]   done_count,
  output logic               busy
);

  if (!(START < STOP)) begin : g_chk_order
    $fatal(1, "note_lane_generator: START must be below STOP");
  end
  if (W < 1 || W > MAX_W) begin : g_chk_w
    $fatal(1, "note_lane_generator: W out of supported range");
  end
  if (longint'(STOP) > ((longint'(1) << W) - 1)) begin : g_chk_stop
    $fatal(1, "note_lane_generator: STOP does not fit in W bits");
  end
  if (STEP < 1) begin : g_chk_step
    $fatal(1, "note_lane_generator: STEP must be at least 1");
  end
  if (LANES < 1) begin : g_chk_lanes
    $fatal(1, "note_lane_generator: LANES must be at least 1");
  end

  localparam int PC_W  = $clog2(LANES + 1);
  localparam int SUM_W = CNT_W + PC_W;

  logic [LANES-1:0] done_set;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    note_lane #(
      .W        (W),
      .START    (START),
      .STOP     (STOP),
      .STEP     (STEP),
      .MODE_WRAP(MODE_WRAP)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .spawn   (spawn[gi]),
      .clear   (clear[gi]),
      .pos     (pos[gi*W +: W]),
      .active  (active[gi]),
      .done    (done[gi]),
      .done_set(done_set[gi])
    );
  end

  // Count from the lanes' next-done bits so the counter moves on the same
  // edge that raises the done pulses.
  logic [PC_W-1:0]  pc;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] done_count_reg, done_count_next;

  always_comb begin
    pc = '0;
    for (int i = 0; i < LANES; i++) begin
      pc = pc + PC_W'(done_set[i]);
    end
    sum = SUM_W'(done_count_reg) + SUM_W'(pc);
    if (sum > SUM_W'({CNT_W{1'b1}})) begin
      done_count_next = {CNT_W{1'b1}};
    end else begin
      done_count_next = CNT_W'(sum);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_count_reg <= '0;
    end else begin
      done_count_reg <= done_count_next;
    end
  end

  assign done_count = done_count_reg;
  assign busy       = |active;

endmodule
